// File: rtl/alu_decode_md.sv
// ALU control decoder with an iterative M-extension unit (shift-add multiply, restoring divide).
// Divider support is included only when ALU_DECODE_MD_DIV_EN is defined.
module alu_decode_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [2:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [3:0]       Operation,
  output logic             op_valid,
  output logic             illegal,
  output logic             md_done,
  output logic [WIDTH-1:0] md_result
);

  // state | meaning
  // IDLE  | ready for a request
  // CALC  | one shift-add / restoring-divide step per cycle
  // DONE  | md_result valid, md_done strobe
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd, hi, lo;
  logic [WIDTH-1:0] hi_n, lo_n, final_res;
  logic [2:0]       md_f3;
  logic             neg, spec;

  logic       accept;
  logic [3:0] dec_op;
  logic       dec_ill, dec_md;

  assign busy    = (state != IDLE);
  assign md_done = (state == DONE);
  assign accept  = in_valid & ~busy & ~flush;

  always_comb begin
    dec_op  = 4'b0000;
    dec_ill = 1'b0;
    dec_md  = 1'b0;
    case (ALUOp)
      3'b000: dec_op = (Funct3 == 3'b010) ? 4'b0100 : 4'b0000;
      3'b001: begin
        case (Funct3)
          3'b000:  dec_op = 4'b1000;
          3'b001:  dec_op = 4'b1001;
          3'b100:  dec_op = 4'b1010;
          3'b101:  dec_op = 4'b1011;
          default: dec_ill = 1'b1;
        endcase
      end
      3'b010: begin
        if (Funct7 == 7'b0000000) begin
          case (Funct3)
            3'b000:  dec_op = 4'b0100;
            3'b111:  dec_op = 4'b0000;
            3'b110:  dec_op = 4'b0001;
            3'b100:  dec_op = 4'b0010;
            3'b010:  dec_op = 4'b1010;
            default: dec_ill = 1'b1;
          endcase
        end else if (Funct7 == 7'b0100000 && Funct3 == 3'b000) begin
          dec_op = 4'b0101;
        end else if (Funct7 == 7'b0000001) begin
`ifdef ALU_DECODE_MD_DIV_EN
          dec_md = 1'b1;
          dec_op = 4'b1111;
`else
          if (!Funct3[2]) begin
            dec_md = 1'b1;
            dec_op = 4'b1111;
          end else begin
            dec_ill = 1'b1;
          end
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      3'b011: begin
        case (Funct3)
          3'b000: dec_op = 4'b0100;
          3'b010: dec_op = 4'b1010;
          3'b001: begin
            if (Funct7 == 7'b0000000) dec_op = 4'b1100;
            else dec_ill = 1'b1;
          end
          3'b101: begin
            if (Funct7 == 7'b0000000) dec_op = 4'b1101;
            else if (Funct7 == 7'b0100000) dec_op = 4'b1110;
            else dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Signed operands are reduced to magnitudes; the sign is re-applied to the final value.
  logic             a_sgn, b_sgn, neg_init;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign a_sgn = SrcA[WIDTH-1] & ((Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                                  (Funct3 == 3'b100) || (Funct3 == 3'b110));
  assign b_sgn = SrcB[WIDTH-1] & ((Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                                  (Funct3 == 3'b110));
  assign mag_a    = a_sgn ? -SrcA : SrcA;
  assign mag_b    = b_sgn ? -SrcB : SrcB;
  assign neg_init = (Funct3 == 3'b110) ? a_sgn : (a_sgn ^ b_sgn);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    hi_n      = mul_sum[WIDTH:1];
    lo_n      = {mul_sum[0], lo[WIDTH-1:1]};
    prod      = {hi_n, lo_n};
    prod_s    = neg ? -prod : prod;
    final_res = (md_f3 == 3'b000) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
`ifdef ALU_DECODE_MD_DIV_EN
    if (md_f3[2]) begin
      // Restoring step: hi is the partial remainder, lo shifts the dividend out and quotient in.
      mul_sum = {hi, lo[WIDTH-1]} - {1'b0, opnd};
      if (!mul_sum[WIDTH]) begin
        hi_n = mul_sum[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
      if (md_f3[1]) final_res = neg ? -hi_n : hi_n;
      else          final_res = neg ? -lo_n : lo_n;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && dec_md) state_nxt = CALC;
      CALC: begin
        if (flush) state_nxt = IDLE;
        else if (spec || cnt == CW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      Operation <= 4'b0000;
      op_valid  <= 1'b0;
      illegal   <= 1'b0;
      md_result <= '0;
      cnt       <= '0;
      opnd      <= '0;
      hi        <= '0;
      lo        <= '0;
      md_f3     <= 3'b000;
      neg       <= 1'b0;
      spec      <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_valid <= accept;
      illegal  <= accept & dec_ill;
      if (accept) Operation <= dec_op;
      if (accept && dec_md) begin
        md_f3 <= Funct3;
        neg   <= neg_init;
        cnt   <= CW'(WIDTH);
        hi    <= '0;
        spec  <= 1'b0;
        if (!Funct3[2]) begin
          opnd <= (Funct3 == 3'b000) ? SrcA : mag_a;
          lo   <= (Funct3 == 3'b000) ? SrcB : mag_b;
        end else begin
          opnd <= mag_b;
          lo   <= mag_a;
`ifdef ALU_DECODE_MD_DIV_EN
          // Zero divisor and signed overflow finish directly from hi without iterating.
          if (SrcB == '0) begin
            spec <= 1'b1;
            hi   <= Funct3[1] ? SrcA : {WIDTH{1'b1}};
          end else if (!Funct3[0] && SrcA == {1'b1, {(WIDTH-1){1'b0}}} &&
                       SrcB == {WIDTH{1'b1}}) begin
            spec <= 1'b1;
            hi   <= Funct3[1] ? '0 : SrcA;
          end
`endif
        end
      end else if (state == CALC && !flush) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt - CW'(1);
        if (spec) md_result <= hi;
        else if (cnt == CW'(1)) md_result <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_md.sv
// Self-checking bench for alu_decode_md: decode vector table plus multi-cycle M-unit sequences.
module tb_alu_decode_md;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush;
  logic [2:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        busy, op_valid, illegal, md_done;
  logic [3:0]  Operation;
  logic [31:0] md_result;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_res;

  alu_decode_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .Operation(Operation), .op_valid(op_valid), .illegal(illegal),
    .md_done(md_done), .md_result(md_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
    logic       ill;
  } dvec_t;

  typedef struct {
    string       nm;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } mvec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [6:0] f7, input logic [2:0] f3);
    ALUOp = a; Funct7 = f7; Funct3 = f3;
  endtask

  task automatic run_md(input mvec_t v);
    int   k;
    logic busy_ok;
    drive(3'b010, 7'b0000001, v.f3);
    SrcA = v.a; SrcB = v.b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    SrcA = $urandom; SrcB = $urandom;
    chk({v.nm, " op"}, Operation, 4'b1111);
    chk({v.nm, " op_valid"}, op_valid, 1);
    chk({v.nm, " busy1"}, busy, 1);
    k = 1;
    busy_ok = 1'b1;
    while (!md_done && k < 40) begin
      if (!busy) busy_ok = 1'b0;
      step();
      k++;
    end
    chk({v.nm, " latency"}, k, v.lat);
    chk({v.nm, " busy held"}, busy_ok & busy, 1);
    chk({v.nm, " result"}, md_result, v.exp);
    step();
    chk({v.nm, " done low"}, md_done, 0);
    chk({v.nm, " busy end"}, busy, 0);
    chk({v.nm, " result held"}, md_result, v.exp);
    last_res = v.exp;
  endtask

  dvec_t dv[23];
  mvec_t mv[$];

  initial begin
    int   k;
    logic seen;

    dv[0]  = '{3'b000, 7'h00, 3'b010, 4'b0100, 1'b0};
    dv[1]  = '{3'b000, 7'h00, 3'b000, 4'b0000, 1'b0};
    dv[2]  = '{3'b000, 7'h55, 3'b011, 4'b0000, 1'b0};
    dv[3]  = '{3'b001, 7'h00, 3'b000, 4'b1000, 1'b0};
    dv[4]  = '{3'b001, 7'h00, 3'b001, 4'b1001, 1'b0};
    dv[5]  = '{3'b001, 7'h00, 3'b100, 4'b1010, 1'b0};
    dv[6]  = '{3'b001, 7'h00, 3'b101, 4'b1011, 1'b0};
    dv[7]  = '{3'b001, 7'h00, 3'b010, 4'b0000, 1'b1};
    dv[8]  = '{3'b010, 7'h00, 3'b000, 4'b0100, 1'b0};
    dv[9]  = '{3'b010, 7'h00, 3'b111, 4'b0000, 1'b0};
    dv[10] = '{3'b010, 7'h00, 3'b110, 4'b0001, 1'b0};
    dv[11] = '{3'b010, 7'h00, 3'b100, 4'b0010, 1'b0};
    dv[12] = '{3'b010, 7'h00, 3'b010, 4'b1010, 1'b0};
    dv[13] = '{3'b010, 7'h20, 3'b000, 4'b0101, 1'b0};
    dv[14] = '{3'b010, 7'h20, 3'b101, 4'b0000, 1'b1};
    dv[15] = '{3'b010, 7'h00, 3'b001, 4'b0000, 1'b1};
    dv[16] = '{3'b011, 7'h00, 3'b000, 4'b0100, 1'b0};
    dv[17] = '{3'b011, 7'h00, 3'b010, 4'b1010, 1'b0};
    dv[18] = '{3'b011, 7'h00, 3'b001, 4'b1100, 1'b0};
    dv[19] = '{3'b011, 7'h00, 3'b101, 4'b1101, 1'b0};
    dv[20] = '{3'b011, 7'h20, 3'b101, 4'b1110, 1'b0};
    dv[21] = '{3'b011, 7'h00, 3'b011, 4'b0000, 1'b1};
    dv[22] = '{3'b100, 7'h00, 3'b000, 4'b0000, 1'b1};

    mv.push_back('{"MUL",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    mv.push_back('{"MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    mv.push_back('{"MULH",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    mv.push_back('{"MULHSU", 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33});
    mv.push_back('{"MULHmin",3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
`ifdef ALU_DECODE_MD_DIV_EN
    mv.push_back('{"DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
    mv.push_back('{"DIVU0",  3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2});
    mv.push_back('{"REMneg", 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    mv.push_back('{"DIVneg", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    mv.push_back('{"DIVU",   3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33});
    mv.push_back('{"REMU",   3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33});
    mv.push_back('{"REM0",   3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2});
    mv.push_back('{"REMovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2});
`endif

    reset = 1'b1; in_valid = 1'b1; flush = 1'b0;
    drive(3'b010, 7'h00, 3'b000);
    SrcA = 32'h1; SrcB = 32'h2;
    step(); step();
    chk("rst busy", busy, 0);
    chk("rst op_valid", op_valid, 0);
    chk("rst illegal", illegal, 0);
    chk("rst md_done", md_done, 0);
    chk("rst Operation", Operation, 0);
    chk("rst md_result", md_result, 0);
    reset = 1'b0; in_valid = 1'b0;
    step();

    for (int i = 0; i < 23; i++) begin
      drive(dv[i].aluop, dv[i].f7, dv[i].f3);
      in_valid = 1'b1;
      step();
      chk($sformatf("dec%0d op", i), Operation, dv[i].op);
      chk($sformatf("dec%0d valid", i), op_valid, 1);
      chk($sformatf("dec%0d illegal", i), illegal, dv[i].ill);
      chk($sformatf("dec%0d busy", i), busy, 0);
    end
    in_valid = 1'b0;
    step();
    chk("idle op_valid", op_valid, 0);
    chk("idle illegal", illegal, 0);

    drive(3'b001, 7'h00, 3'b010);
    in_valid = 1'b1; flush = 1'b1;
    step();
    chk("flush beats valid", op_valid, 0);
    chk("flush no illegal", illegal, 0);
    in_valid = 1'b0; flush = 1'b0;
    step();

    foreach (mv[i]) run_md(mv[i]);

`ifndef ALU_DECODE_MD_DIV_EN
    drive(3'b010, 7'b0000001, 3'b111);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("REMu illegal", illegal, 1);
    chk("REMu Operation", Operation, 0);
    chk("REMu op_valid", op_valid, 1);
    chk("REMu busy", busy, 0);
    step();
    chk("REMu busy after", busy, 0);
`endif

`ifdef ALU_DECODE_MD_DIV_EN
    drive(3'b010, 7'b0000001, 3'b101);
`else
    drive(3'b010, 7'b0000001, 3'b000);
`endif
    SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (k = 1; k < 10; k++) step();
    chk("flush pre busy", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush md_done", md_done, 0);
    chk("flush op_valid", op_valid, 0);
    drive(3'b010, 7'h00, 3'b000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post-flush ADD valid", op_valid, 1);
    chk("post-flush ADD op", Operation, 4'b0100);
    seen = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (md_done) seen = 1'b1;
      step();
    end
    chk("flush no md_done", seen, 0);
    chk("flush result kept", md_result, last_res);

    drive(3'b010, 7'b0000001, 3'b000);
    SrcA = 32'd9; SrcB = 32'd11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (k = 1; k < 10; k++) step();
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step();
    chk("midrst busy", busy, 0);
    chk("midrst op_valid", op_valid, 0);
    chk("midrst illegal", illegal, 0);
    chk("midrst md_done", md_done, 0);
    chk("midrst Operation", Operation, 0);
    chk("midrst md_result", md_result, 0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    chk("midrst stays idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
